// File: rtl/calculator_pkg.sv
// Shared widths, address/data types and the sequencer state encoding for the
// calculator datapath.
package calculator_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  // One bit wider than an address so a full 2^ADDR_W-word window is representable.
  typedef logic [ADDR_W:0]   span_t;

  typedef enum logic [2:0] {
    IDLE,
    READ_A,
    READ_B,
    ADD,
    WRITE,
    DONE
  } state_t;

  // Number of words in an inclusive window; only meaningful when last >= first.
  function automatic span_t window_span(input addr_t first, input addr_t last);
    return span_t'({1'b0, last}) - span_t'({1'b0, first}) + span_t'(1);
  endfunction

endpackage

// File: rtl/adder32.sv
// Combinational 32-bit ripple-carry adder; the carry out of bit 31 is dropped,
// so the sum wraps modulo 2^32.
module adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  logic [31:0] carry;

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ carry[gi];
    if (gi < 31) begin : g_carry
      assign carry[gi+1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Operand-fetch / write-back controller: reads an SRAM window two words at a
// time, adds each pair through adder32 and writes the sums to a second window.
module calc_sequencer
  import calculator_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] read_start_addr_i,
  input  logic [ADDR_W-1:0] read_end_addr_i,
  input  logic [ADDR_W-1:0] write_start_addr_i,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] result_count_o
);

  state_t state_reg, state_next;
  addr_t  rd_ptr_reg, rd_ptr_next;
  addr_t  end_reg, end_next;
  addr_t  wr_ptr_reg, wr_ptr_next;
  addr_t  count_reg, count_next;
  addr_t  result_count_reg, result_count_next;
  span_t  left_reg, left_next;
  data_t  op_a_reg, op_a_next;
  data_t  result_reg, result_next;
  logic   last_b_reg, last_b_next;

  data_t  add_b;
  data_t  add_sum;

  // A lone trailing operand is added to zero rather than to stale read data.
  assign add_b = last_b_reg ? mem_rdata_i : '0;

  adder32 u_adder (
    .a_i   (op_a_reg),
    .b_i   (add_b),
    .sum_o (add_sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= IDLE;
      rd_ptr_reg       <= '0;
      end_reg          <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= '0;
      result_count_reg <= '0;
      left_reg         <= '0;
      op_a_reg         <= '0;
      result_reg       <= '0;
      last_b_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rd_ptr_reg       <= rd_ptr_next;
      end_reg          <= end_next;
      wr_ptr_reg       <= wr_ptr_next;
      count_reg        <= count_next;
      result_count_reg <= result_count_next;
      left_reg         <= left_next;
      op_a_reg         <= op_a_next;
      result_reg       <= result_next;
      last_b_reg       <= last_b_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    rd_ptr_next       = rd_ptr_reg;
    end_next          = end_reg;
    wr_ptr_next       = wr_ptr_reg;
    count_next        = count_reg;
    result_count_next = result_count_reg;
    left_next         = left_reg;
    op_a_next         = op_a_reg;
    result_next       = result_reg;
    last_b_next       = last_b_reg;
    mem_rd_en_o       = 1'b0;
    mem_wr_en_o       = 1'b0;
    mem_addr_o        = '0;
    mem_wdata_o       = '0;
    busy_o            = 1'b0;
    done_o            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          rd_ptr_next = read_start_addr_i;
          end_next    = read_end_addr_i;
          wr_ptr_next = write_start_addr_i;
          count_next  = '0;
          if (read_end_addr_i < read_start_addr_i) begin
            left_next         = '0;
            result_count_next = '0;
            state_next        = DONE;
          end else begin
            left_next  = window_span(read_start_addr_i, read_end_addr_i);
            state_next = READ_A;
          end
        end
      end

      READ_A: begin
        busy_o      = 1'b1;
        mem_rd_en_o = 1'b1;
        mem_addr_o  = rd_ptr_reg;
        state_next  = READ_B;
      end

      READ_B: begin
        busy_o    = 1'b1;
        op_a_next = mem_rdata_i;
        if (rd_ptr_reg == end_reg) begin
          last_b_next = 1'b0;
          rd_ptr_next = rd_ptr_reg + addr_t'(1);
          left_next   = left_reg - span_t'(1);
        end else begin
          mem_rd_en_o = 1'b1;
          mem_addr_o  = rd_ptr_reg + addr_t'(1);
          last_b_next = 1'b1;
          rd_ptr_next = rd_ptr_reg + addr_t'(2);
          left_next   = left_reg - span_t'(2);
        end
        state_next = ADD;
      end

      ADD: begin
        busy_o      = 1'b1;
        result_next = add_sum;
        state_next  = WRITE;
      end

      WRITE: begin
        busy_o      = 1'b1;
        mem_wr_en_o = 1'b1;
        mem_addr_o  = wr_ptr_reg;
        mem_wdata_o = result_reg;
        wr_ptr_next = wr_ptr_reg + addr_t'(1);
        count_next  = count_reg + addr_t'(1);
        // The remaining-word counter, not the pointer, ends the run, so a
        // window ending at the top address cannot wrap into an endless loop.
        if (left_reg == '0) begin
          result_count_next = count_reg + addr_t'(1);
          state_next        = DONE;
        end else begin
          state_next = READ_A;
        end
      end

      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign result_count_o = result_count_reg;

endmodule
